// File: rtl/uart_cmd_responder_pkg.sv
// Shared constants and state encodings for the UART command responder.
// Opcodes and reply bytes are the wire values seen by the host.
package uart_cmd_responder_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_PING  = 8'h50;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_MEM_CAP,
        ST_TX_REQ,
        ST_TX_WAIT_START,
        ST_TX_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_WAIT_START,
        HS_WAIT_DONE
    } hs_state_t;

    typedef enum logic [1:0] {
        OPK_READ,
        OPK_WRITE,
        OPK_OTHER
    } op_kind_t;

    function automatic logic in_frame(state_t s);
        return s inside {ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO};
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte-stream and memory-port bundle between the responder and its neighbours.
// master = responder side, slave = UART/memory side.
interface uart_cmd_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              byte_ready;
    logic [7:0]        data_in;
    logic              byte_ready_out;
    logic [7:0]        data_out;
    logic              byte_sending;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  byte_ready, data_in, byte_sending, mem_rdata,
        output byte_ready_out, data_out, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        output byte_ready, data_in, byte_sending, mem_rdata,
        input  byte_ready_out, data_out, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/uart_tx_handshake.sv
// Per-byte request/acknowledge with the UART transmitter: raise byte_ready_out,
// drop it once byte_sending is seen, then report completion when it falls.
module uart_tx_handshake
    import uart_cmd_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       byte_sending,
    output logic       byte_ready_out,
    output logic [7:0] data_out,
    output logic       started,
    output logic       done
);

    hs_state_t  hs_q, hs_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q   <= HS_IDLE;
            data_q <= 8'h00;
        end else begin
            hs_q   <= hs_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        hs_d    = hs_q;
        data_d  = data_q;
        started = 1'b0;
        done    = 1'b0;
        case (hs_q)
            HS_IDLE: begin
                if (load) begin
                    data_d = tx_byte;
                    hs_d   = HS_WAIT_START;
                end
            end
            HS_WAIT_START: begin
                if (byte_sending) begin
                    started = 1'b1;
                    hs_d    = HS_WAIT_DONE;
                end
            end
            HS_WAIT_DONE: begin
                if (!byte_sending) begin
                    done = 1'b1;
                    hs_d = HS_IDLE;
                end
            end
            default: hs_d = HS_IDLE;
        endcase
    end

    // The request is visible in the load cycle itself so the reply latency holds.
    assign byte_ready_out = load || (hs_q == HS_WAIT_START);
    assign data_out       = load ? tx_byte : data_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes read/write/ping frames arriving over the UART byte interface, performs
// the MU0 memory access and streams the reply bytes back to the transmitter.
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2700000,
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_cmd_responder_if.master bus,
    output logic                 busy,
    output logic                 rx_overrun
);

    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    op_kind_t          op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [15:0]       reply_q, reply_d;
    logic              two_q, two_d;
    logic              idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic       hs_load;
    logic [7:0] tx_byte;
    logic       hs_started;
    logic       hs_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OPK_OTHER;
            addr_q  <= '0;
            wdata_q <= '0;
            reply_q <= '0;
            two_q   <= 1'b0;
            idx_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            reply_q <= reply_d;
            two_q   <= two_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        reply_d = reply_q;
        two_d   = two_q;
        idx_d   = idx_q;
        timer_d = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.byte_ready) begin
                    two_d = 1'b0;
                    case (bus.data_in)
                        OP_READ: begin
                            op_d    = OPK_READ;
                            state_d = ST_ADDR_HI;
                        end
                        OP_WRITE: begin
                            op_d    = OPK_WRITE;
                            state_d = ST_ADDR_HI;
                        end
                        OP_PING: begin
                            op_d    = OPK_OTHER;
                            reply_d = {OP_PING, 8'h00};
                            state_d = ST_MEM_CAP;
                        end
                        default: begin
                            op_d    = OPK_OTHER;
                            reply_d = {RSP_ERR, 8'h00};
                            state_d = ST_MEM_CAP;
                        end
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (bus.byte_ready) begin
                    addr_d[ADDR_W-1:8] = bus.data_in[ADDR_W-9:0];
                    state_d            = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (bus.byte_ready) begin
                    addr_d[7:0] = bus.data_in;
                    state_d     = (op_q == OPK_WRITE) ? ST_DATA_HI : ST_MEM_RD;
                end
            end
            ST_DATA_HI: begin
                if (bus.byte_ready) begin
                    wdata_d[15:8] = bus.data_in;
                    state_d       = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (bus.byte_ready) begin
                    wdata_d[7:0] = bus.data_in;
                    state_d      = ST_MEM_WR;
                end
            end
            ST_MEM_WR: begin
                reply_d = {RSP_ACK, 8'h00};
                two_d   = 1'b0;
                idx_d   = 1'b0;
                state_d = ST_TX_REQ;
            end
            ST_MEM_RD: state_d = ST_MEM_CAP;
            // Also the one-cycle landing spot for ping/unknown so every
            // single-byte reply starts on the same cycle as a write ack.
            ST_MEM_CAP: begin
                if (op_q == OPK_READ) begin
                    reply_d = 16'(bus.mem_rdata);
                    two_d   = 1'b1;
                end
                idx_d   = 1'b0;
                state_d = ST_TX_REQ;
            end
            ST_TX_REQ: state_d = ST_TX_WAIT_START;
            ST_TX_WAIT_START: begin
                if (hs_started) state_d = ST_TX_WAIT_DONE;
            end
            ST_TX_WAIT_DONE: begin
                if (hs_done) begin
                    if (two_q && !idx_q) begin
                        idx_d   = 1'b1;
                        state_d = ST_TX_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte timeout; an arriving byte always beats expiry.
        if (in_frame(state_q)) begin
            if (bus.byte_ready) begin
                timer_d = '0;
            end else if (timer_q == T_LAST) begin
                timer_d = '0;
                state_d = ST_IDLE;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    assign hs_load = (state_q == ST_TX_REQ);
    assign tx_byte = idx_q ? reply_q[7:0] : reply_q[15:8];

    uart_tx_handshake u_tx (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (hs_load),
        .tx_byte        (tx_byte),
        .byte_sending   (bus.byte_sending),
        .byte_ready_out (bus.byte_ready_out),
        .data_out       (bus.data_out),
        .started        (hs_started),
        .done           (hs_done)
    );

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == ST_MEM_WR);
    assign bus.mem_re    = (state_q == ST_MEM_RD);

    assign busy       = (state_q != ST_IDLE);
    assign rx_overrun = bus.byte_ready &&
                        (state_q inside {ST_MEM_WR, ST_MEM_RD, ST_MEM_CAP,
                                         ST_TX_REQ, ST_TX_WAIT_START, ST_TX_WAIT_DONE});

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: byte-level stimulus with a simple
// transmitter model and a memory model that answers 0xBEEF one cycle after mem_re.
module tb_uart_cmd_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic rx_overrun;

    logic       br      = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_hold = 1'b0;

    uart_cmd_responder_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    assign bus.byte_ready   = br;
    assign bus.data_in      = din;
    assign bus.byte_sending = tx_busy;

    uart_cmd_responder #(
        .TIMEOUT_CYCLES (50),
        .ADDR_W         (12),
        .DATA_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .rx_overrun (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_rdata <= bus.mem_re ? 16'hBEEF : 16'h0000;

    int          n_vec = 0;
    int          n_err = 0;
    int          ncyc = 0;
    int          last_br_cyc = 0;
    int          we_cyc = 0;
    int          re_cyc = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          ovr_cnt = 0;
    int          both_cnt = 0;
    int          wide_cnt = 0;
    int          tx_cnt = 0;
    int          gap_cnt = 0;
    logic [11:0] we_addr = '0;
    logic [15:0] we_data = '0;
    logic        prev_bro = 1'b0;
    logic        prev_we = 1'b0;
    logic        prev_re = 1'b0;
    int          rise_cyc[$];
    int          fall_cyc[$];
    logic [7:0]  replies[$];

    // Monitor and transmitter model share one process so ordering is fixed.
    always @(negedge clk) begin
        ncyc++;
        if (br) last_br_cyc = ncyc;
        if (bus.mem_we) begin
            we_cnt++;
            we_cyc  = ncyc;
            we_addr = bus.mem_addr;
            we_data = bus.mem_wdata;
        end
        if (bus.mem_re) begin
            re_cnt++;
            re_cyc = ncyc;
        end
        if (bus.mem_we && bus.mem_re) both_cnt++;
        if ((bus.mem_we && prev_we) || (bus.mem_re && prev_re)) wide_cnt++;
        if (rx_overrun) ovr_cnt++;
        if (bus.byte_ready_out && !prev_bro) rise_cyc.push_back(ncyc);
        prev_bro = bus.byte_ready_out;
        prev_we  = bus.mem_we;
        prev_re  = bus.mem_re;

        if (tx_cnt != 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_busy = 1'b0;
                gap_cnt = 2;
                fall_cyc.push_back(ncyc);
            end
        end else if (gap_cnt != 0) begin
            gap_cnt--;
        end else if (bus.byte_ready_out && !tx_hold) begin
            replies.push_back(bus.data_out);
            tx_busy = 1'b1;
            tx_cnt  = 8;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] reply_at(input int i);
        if (i < replies.size()) return {24'h0, replies[i]};
        return 32'hDEAD_0000;
    endfunction

    function automatic int rise_at(input int i);
        if (i < rise_cyc.size()) return rise_cyc[i];
        return -1000;
    endfunction

    function automatic int fall_at(input int i);
        if (i < fall_cyc.size()) return fall_cyc[i];
        return 1000000;
    endfunction

    task automatic clear_mon();
        replies.delete();
        rise_cyc.delete();
        fall_cyc.delete();
        we_cnt  = 0;
        re_cnt  = 0;
        ovr_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        br  = 1'b1;
        din = b;
        @(posedge clk); #2;
        br  = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (!busy && !tx_busy) break;
        end
        check_val(tag, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_bro",   {31'h0, bus.byte_ready_out}, 32'h0);
        check_val("rst_busy",  {31'h0, busy},               32'h0);
        check_val("rst_we",    {31'h0, bus.mem_we},         32'h0);
        check_val("rst_re",    {31'h0, bus.mem_re},         32'h0);
        check_val("rst_dout",  {24'h0, bus.data_out},       32'h0);
        check_val("rst_addr",  {20'h0, bus.mem_addr},       32'h0);
        check_val("rst_ovr",   {31'h0, rx_overrun},         32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ping
        clear_mon();
        send_byte(8'h50);
        wait_idle("ping_idle");
        check_val("ping_cnt",  replies.size(), 32'd1);
        check_val("ping_byte", reply_at(0), 32'h50);
        check_val("ping_lat",  rise_at(0) - last_br_cyc, 32'd2);
        check_val("ping_we",   we_cnt, 32'd0);
        check_val("ping_re",   re_cnt, 32'd0);

        // Write
        clear_mon();
        send_byte(8'h57); send_byte(8'hF1); send_byte(8'h23);
        send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("wr_idle");
        check_val("wr_we_cnt", we_cnt, 32'd1);
        check_val("wr_addr",   {20'h0, we_addr}, 32'h123);
        check_val("wr_data",   {16'h0, we_data}, 32'hBEEF);
        check_val("wr_we_lat", we_cyc - last_br_cyc, 32'd1);
        check_val("wr_lat",    rise_at(0) - last_br_cyc, 32'd2);
        check_val("wr_cnt",    replies.size(), 32'd1);
        check_val("wr_ack",    reply_at(0), 32'h4B);
        check_val("wr_hold",   {20'h0, bus.mem_addr}, 32'h123);

        // Read
        clear_mon();
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h23);
        wait_idle("rd_idle");
        check_val("rd_re_cnt", re_cnt, 32'd1);
        check_val("rd_re_lat", re_cyc - last_br_cyc, 32'd1);
        check_val("rd_lat",    rise_at(0) - last_br_cyc, 32'd3);
        check_val("rd_cnt",    replies.size(), 32'd2);
        check_val("rd_hi",     reply_at(0), 32'hBE);
        check_val("rd_lo",     reply_at(1), 32'hEF);
        check_val("rd_order",  {31'h0, rise_at(1) > fall_at(0)}, 32'h1);
        check_val("rd_we",     we_cnt, 32'd0);

        // Unknown opcode then ping
        clear_mon();
        send_byte(8'hAA);
        wait_idle("unk_idle");
        check_val("unk_cnt",  replies.size(), 32'd1);
        check_val("unk_byte", reply_at(0), 32'h3F);
        check_val("unk_lat",  rise_at(0) - last_br_cyc, 32'd2);
        clear_mon();
        send_byte(8'h50);
        wait_idle("unk_ping_idle");
        check_val("unk_ping", reply_at(0), 32'h50);

        // Timeout inside a write frame
        clear_mon();
        send_byte(8'h57); send_byte(8'h00);
        repeat (20) @(posedge clk);
        #1;
        check_val("to_busy_mid",  {31'h0, busy}, 32'h1);
        repeat (40) @(posedge clk);
        #1;
        check_val("to_busy_end",  {31'h0, busy}, 32'h0);
        check_val("to_cnt",       replies.size(), 32'd0);
        check_val("to_we",        we_cnt, 32'd0);
        send_byte(8'h50);
        wait_idle("to_ping_idle");
        check_val("to_ping_cnt",  replies.size(), 32'd1);
        check_val("to_ping",      reply_at(0), 32'h50);

        // Overrun while the reply byte is being shifted
        clear_mon();
        send_byte(8'h50);
        for (int k = 0; k < 50 && !tx_busy; k++) @(posedge clk);
        check_val("ovr_sending", {31'h0, tx_busy}, 32'h1);
        @(posedge clk); #2;
        br  = 1'b1;
        din = 8'h52;
        #2;
        check_val("ovr_pulse", {31'h0, rx_overrun}, 32'h1);
        @(posedge clk); #2;
        br = 1'b0;
        wait_idle("ovr_idle");
        check_val("ovr_cnt",   ovr_cnt, 32'd1);
        check_val("ovr_rcnt",  replies.size(), 32'd1);
        check_val("ovr_byte",  reply_at(0), 32'h50);
        check_val("ovr_re",    re_cnt, 32'd0);

        // Reset while waiting for the transmitter to start
        clear_mon();
        tx_hold = 1'b1;
        send_byte(8'h50);
        #1;
        check_val("arst_pre_bro",  {31'h0, bus.byte_ready_out}, 32'h1);
        check_val("arst_pre_busy", {31'h0, busy}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("arst_bro",  {31'h0, bus.byte_ready_out}, 32'h0);
        check_val("arst_busy", {31'h0, busy}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        tx_hold = 1'b0;
        rst_n   = 1'b1;
        repeat (2) @(posedge clk);
        check_val("arst_norx", replies.size(), 32'd0);
        send_byte(8'h50);
        wait_idle("arst_ping_idle");
        check_val("arst_ping", reply_at(0), 32'h50);

        check_val("strobe_both", both_cnt, 32'd0);
        check_val("strobe_wide", wide_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
